// File: rtl/pio_gpio_ext.sv
// Bidirectional Avalon-MM parallel I/O with per-bit direction, atomic set/clear and edge-capture IRQ.
// Define PIO_GPIO_EDGE_IRQ_EN to build the edge detector, IRQMASK/EDGECAP registers and irq.
module pio_gpio_ext #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0,
  parameter int               EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] data_view;
  logic [WIDTH-1:0] rd_bits;
  logic             unused_inputs;

  assign wr_en         = chipselect & ~write_n;
  assign wr_data       = writedata[WIDTH-1:0];
  assign unused_inputs = ^{read_n, writedata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= RESET_OUT;
    end else if (wr_en) begin
      case (address)
        3'd0:    out_reg <= wr_data;
        3'd4:    out_reg <= out_reg | wr_data;
        3'd5:    out_reg <= out_reg & ~wr_data;
        default: out_reg <= out_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_reg <= RESET_DIR;
    end else if (wr_en && address == 3'd1) begin
      dir_reg <= wr_data;
    end
  end

  // gpio_in is asynchronous to clk; only sync2 is safe to consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  assign gpio_out  = out_reg;
  assign gpio_oe   = dir_reg;
  assign data_view = (out_reg & dir_reg) | (sync2 & ~dir_reg);

`ifdef PIO_GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] cap_clr;

  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      0:       edges = sync2 & ~prev;
      1:       edges = ~sync2 & prev;
      default: edges = sync2 ^ prev;
    endcase
  end

  assign cap_clr = (wr_en && address == 3'd3) ? wr_data : '0;

  // A newly detected edge wins over a W1C of the same bit in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      prev     <= sync2;
      edge_cap <= (edge_cap & ~cap_clr) | edges;
      if (wr_en && address == 3'd2) begin
        irq_mask <= wr_data;
      end
    end
  end

  assign irq = |(edge_cap & irq_mask);
`else
  localparam int unused_edge_type = EDGE_TYPE;

  assign irq = 1'b0;
`endif

  always_comb begin
    rd_bits = '0;
    case (address)
      3'd0:    rd_bits = data_view;
      3'd1:    rd_bits = dir_reg;
`ifdef PIO_GPIO_EDGE_IRQ_EN
      3'd2:    rd_bits = irq_mask;
      3'd3:    rd_bits = edge_cap;
`endif
      default: rd_bits = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_bits;
  end

endmodule

// File: tb/tb_pio_gpio_ext.sv
// Self-checking bench for pio_gpio_ext: two instances (rising-edge and any-edge capture) on one bus,
// checked against an input-history reference model; follows PIO_GPIO_EDGE_IRQ_EN like the design.
module tb_pio_gpio_ext;

`ifdef PIO_GPIO_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic        read_n     = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [7:0]  gpio_in    = 8'd0;
  logic [31:0] rd0, rd1;
  logic [7:0]  out0, out1, oe0, oe1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_gpio_ext #(.WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'hF0), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd0),
    .gpio_in(gpio_in), .gpio_out(out0), .gpio_oe(oe0), .irq(irq0)
  );

  pio_gpio_ext #(.WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'hF0), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rd1),
    .gpio_in(gpio_in), .gpio_out(out1), .gpio_oe(oe1), .irq(irq1)
  );

  // Reference model: h0 is the pin value seen at the latest clock edge, h1 the one before, h2 before that.
  // DATA reads the value two edges old; an edge is reported when that value differs from the one before it.
  logic [7:0] m_out, m_dir, m_mask;
  logic [7:0] m_cap [2];
  logic [7:0] h0, h1, h2;
  logic [7:0] m_rise, m_fall, m_clr;
  logic       m_wr;

  assign m_wr   = chipselect && !write_n;
  assign m_rise = h1 & ~h2;
  assign m_fall = ~h1 & h2;
  assign m_clr  = (m_wr && address == 3'd3) ? writedata[7:0] : 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out    <= 8'hA5;
      m_dir    <= 8'hF0;
      m_mask   <= 8'h00;
      m_cap[0] <= 8'h00;
      m_cap[1] <= 8'h00;
      h0       <= 8'h00;
      h1       <= 8'h00;
      h2       <= 8'h00;
    end else begin
      if (m_wr) begin
        case (address)
          3'd0: m_out  <= writedata[7:0];
          3'd1: m_dir  <= writedata[7:0];
          3'd2: m_mask <= writedata[7:0];
          3'd4: m_out  <= m_out | writedata[7:0];
          3'd5: m_out  <= m_out & ~writedata[7:0];
          default: ;
        endcase
      end
      m_cap[0] <= EDGE_EN ? ((m_cap[0] & ~m_clr) | m_rise) : 8'h00;
      m_cap[1] <= EDGE_EN ? ((m_cap[1] & ~m_clr) | m_rise | m_fall) : 8'h00;
      h2 <= h1;
      h1 <= h0;
      h0 <= gpio_in;
    end
  end

  function automatic logic [31:0] m_read(input int inst, input logic [2:0] a);
    case (a)
      3'd0:    m_read = {24'd0, (m_out & m_dir) | (h1 & ~m_dir)};
      3'd1:    m_read = {24'd0, m_dir};
      3'd2:    m_read = EDGE_EN ? {24'd0, m_mask} : 32'd0;
      3'd3:    m_read = EDGE_EN ? {24'd0, m_cap[inst]} : 32'd0;
      default: m_read = 32'd0;
    endcase
  endfunction

  function automatic logic m_irq(input int inst);
    m_irq = EDGE_EN && (|(m_cap[inst] & m_mask));
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #10;
    checks++; if (out0 !== 8'hA5) begin errors++; $display("[TB] FAIL reset_out: got %h expected %h", out0, 8'hA5); end
    checks++; if (oe0 !== 8'hF0) begin errors++; $display("[TB] FAIL reset_oe: got %h expected %h", oe0, 8'hF0); end
    checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b%b expected 00", irq0, irq1); end
    @(negedge clk);
    reset = 1'b0;
    address = 3'd0;
    #1;
    checks++; if (rd0 !== 32'h0000_00A0) begin errors++; $display("[TB] FAIL reset_data: got %h expected %h", rd0, 32'hA0); end
    checks++; if (rd0 !== m_read(0, 3'd0)) begin errors++; $display("[TB] FAIL reset_data_model: got %h expected %h", rd0, m_read(0, 3'd0)); end
    address = 3'd2;
    #1;
    checks++; if (rd0 !== 32'd0) begin errors++; $display("[TB] FAIL reset_mask: got %h expected 0", rd0); end
    address = 3'd3;
    #1;
    checks++; if (rd0 !== 32'd0) begin errors++; $display("[TB] FAIL reset_cap: got %h expected 0", rd0); end
  endtask

  task automatic test_out_regs;
    bus_write(3'd1, 32'hFF);
    checks++; if (oe0 !== 8'hFF) begin errors++; $display("[TB] FAIL dir_write: got %h expected ff", oe0); end
    bus_write(3'd0, 32'h0F);
    checks++; if (out0 !== 8'h0F) begin errors++; $display("[TB] FAIL data_write: got %h expected 0f", out0); end
    bus_write(3'd4, 32'h30);
    checks++; if (out0 !== 8'h3F) begin errors++; $display("[TB] FAIL outset: got %h expected 3f", out0); end
    bus_write(3'd5, 32'h03);
    checks++; if (out0 !== 8'h3C || out1 !== 8'h3C) begin errors++; $display("[TB] FAIL outclr: got %h/%h expected 3c", out0, out1); end
    address = 3'd0;
    #1;
    checks++; if (rd0 !== 32'h3C) begin errors++; $display("[TB] FAIL data_read_out: got %h expected 3c", rd0); end
    address = 3'd4;
    #1;
    checks++; if (rd0 !== 32'd0) begin errors++; $display("[TB] FAIL outset_read: got %h expected 0", rd0); end
  endtask

  task automatic test_edge_irq;
    bus_write(3'd1, 32'h00);
    bus_write(3'd2, 32'h01);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    @(negedge clk);
    address = 3'd0;
    #1;
    checks++; if (rd0[0] !== 1'b0) begin errors++; $display("[TB] FAIL sync_latency: got %b expected 0", rd0[0]); end
    @(negedge clk);
    #1;
    checks++; if (rd0[0] !== 1'b1) begin errors++; $display("[TB] FAIL sync_data: got %b expected 1", rd0[0]); end
    checks++; if (irq0 !== m_irq(0)) begin errors++; $display("[TB] FAIL irq_early: got %b expected %b", irq0, m_irq(0)); end
    @(negedge clk);
    address = 3'd3;
    #1;
    checks++; if (rd0 !== m_read(0, 3'd3)) begin errors++; $display("[TB] FAIL cap_rise: got %h expected %h", rd0, m_read(0, 3'd3)); end
    checks++; if (irq0 !== m_irq(0)) begin errors++; $display("[TB] FAIL irq_rise: got %b expected %b", irq0, m_irq(0)); end
    bus_write(3'd3, 32'h01);
    checks++; if (irq0 !== m_irq(0) || irq1 !== m_irq(1)) begin errors++; $display("[TB] FAIL irq_w1c: got %b%b expected %b%b", irq0, irq1, m_irq(0), m_irq(1)); end
  endtask

  task automatic test_w1c_priority;
    @(negedge clk);
    gpio_in[2] = 1'b1;
    @(negedge clk);
    bus_write(3'd3, 32'h04);
    address = 3'd3;
    #1;
    checks++; if (rd0 !== m_read(0, 3'd3)) begin errors++; $display("[TB] FAIL w1c_priority: got %h expected %h", rd0, m_read(0, 3'd3)); end
    checks++; if (irq0 !== m_irq(0)) begin errors++; $display("[TB] FAIL irq_masked_off: got %b expected %b", irq0, m_irq(0)); end
    bus_write(3'd3, 32'hFF);
  endtask

  task automatic test_any_edge;
    @(negedge clk);
    gpio_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    address = 3'd3;
    #1;
    checks++; if (rd1 !== m_read(1, 3'd3)) begin errors++; $display("[TB] FAIL any_rise: got %h expected %h", rd1, m_read(1, 3'd3)); end
    @(negedge clk);
    gpio_in[1] = 1'b0;
    bus_write(3'd3, 32'h02);
    address = 3'd3;
    #1;
    checks++; if (rd1 !== m_read(1, 3'd3)) begin errors++; $display("[TB] FAIL any_w1c: got %h expected %h", rd1, m_read(1, 3'd3)); end
    @(negedge clk);
    #1;
    checks++; if (rd1 !== m_read(1, 3'd3)) begin errors++; $display("[TB] FAIL any_fall: got %h expected %h", rd1, m_read(1, 3'd3)); end
    checks++; if (rd0 !== m_read(0, 3'd3)) begin errors++; $display("[TB] FAIL rise_ignores_fall: got %h expected %h", rd0, m_read(0, 3'd3)); end
  endtask

  task automatic test_reset_async;
    @(negedge clk);
    gpio_in = 8'h00;
    repeat (3) @(negedge clk);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'hFF);
    gpio_in = 8'hFF;
    repeat (3) @(negedge clk);
    address = 3'd3;
    #1;
    checks++; if (rd0 !== m_read(0, 3'd3)) begin errors++; $display("[TB] FAIL cap_all: got %h expected %h", rd0, m_read(0, 3'd3)); end
    checks++; if (irq0 !== m_irq(0)) begin errors++; $display("[TB] FAIL irq_all: got %b expected %b", irq0, m_irq(0)); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out0 !== 8'hA5 || oe0 !== 8'hF0) begin errors++; $display("[TB] FAIL async_reset_regs: got %h/%h expected a5/f0", out0, oe0); end
    checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_irq: got %b%b expected 00", irq0, irq1); end
    checks++; if (rd0 !== 32'd0 || rd1 !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_cap: got %h/%h expected 0", rd0, rd1); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rd0 !== m_read(0, 3'd3)) begin errors++; $display("[TB] FAIL release_edge: got %h expected %h", rd0, m_read(0, 3'd3)); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      gpio_in    = 8'($urandom);
      chipselect = ($urandom_range(0, 2) == 0);
      write_n    = !chipselect;
      read_n     = chipselect;
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      #1;
      checks++; if (rd0 !== m_read(0, address) || rd1 !== m_read(1, address)) begin errors++; $display("[TB] FAIL rand_read a=%0d: got %h/%h expected %h/%h", address, rd0, rd1, m_read(0, address), m_read(1, address)); end
      checks++; if (out0 !== m_out || oe0 !== m_dir || out1 !== m_out || oe1 !== m_dir) begin errors++; $display("[TB] FAIL rand_pins: got %h/%h expected %h/%h", out0, oe0, m_out, m_dir); end
      checks++; if (irq0 !== m_irq(0) || irq1 !== m_irq(1)) begin errors++; $display("[TB] FAIL rand_irq: got %b%b expected %b%b", irq0, irq1, m_irq(0), m_irq(1)); end
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_out_regs();
    test_edge_irq();
    test_w1c_priority();
    test_any_edge();
    test_reset_async();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_gpio_ext.md
# pio_gpio_ext

Parametrised bidirectional Avalon-MM parallel I/O peripheral for the DE0-Nano Qsys system, the general-purpose successor to the output-only LED PIO. It provides up to 32 pins, each with a per-bit direction, atomic set/clear of output bits, synchronised input sampling, and edge capture with a maskable level interrupt to the Nios II. It sits on the system Avalon-MM interconnect as a zero-wait-state slave and drives the board GPIO pads through external tristate buffers.

## Interface
Parameters:
- WIDTH, 8: number of pins, 1..32.
- RESET_OUT, 0: reset value of the output data register (WIDTH bits).
- RESET_DIR, 0: reset value of the direction register (1 = output).
- EDGE_TYPE, 0: edge detected for capture. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe. Informational only; reads have no side effects.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address. Bits above WIDTH read 0.
- gpio_in  in  WIDTH  pad inputs, asynchronous to clk.
- gpio_out  out  WIDTH  output data register.
- gpio_oe  out  WIDTH  output enable, equal to the direction register.
- irq  out  1  level interrupt.

## Operation
- A write occurs when chipselect=1 and write_n=0 at a rising clk edge. Writes to undefined addresses are ignored. Reads of undefined addresses return 0.
- Register map (word addresses):
  - 0 DATA. Read: per bit, the gpio_out bit where dir=1 and the synchronised input where dir=0. Write: loads the out register.
  - 1 DIR. Read/write.
  - 2 IRQMASK. Read/write.
  - 3 EDGECAP. Read: the capture bits. Write: 1 clears the bit (W1C); 0 leaves it unchanged.
  - 4 OUTSET. Write: out |= writedata. Reads 0.
  - 5 OUTCLR. Write: out &= ~writedata. Reads 0.
- Input path:
  - Two-flop synchroniser sync1 -> sync2, then a delay flop prev.
  - Edge is detected when sync2 differs from prev according to EDGE_TYPE.
  - Capture runs on all bits regardless of DIR.
- Capture bit set has priority: an edge detected in the same cycle as a W1C of that bit leaves the bit set.
- irq = OR over (edgecap & irqmask).
- Reset values:
  - out = RESET_OUT; dir = RESET_DIR; irqmask = 0; edgecap = 0.
  - sync1, sync2 and prev = 0, so gpio_in held high through reset produces one rising edge after release.
  - gpio_out = RESET_OUT; gpio_oe = RESET_DIR; irq = 0.
- Reset asserted at any point clears all state immediately, independent of clk.

## Timing
- Register write: the new value is visible on gpio_out, gpio_oe and readdata in the cycle after the write edge.
- readdata: combinational, zero wait states, read latency 0.
- Input sampling: gpio_in changes before edge N.
  - sync2 holds the new value after N+1; DATA reads it from then on.
  - edgecap bit sets at N+2; irq rises at N+2 if the bit is masked in.
- W1C of the only pending, masked bit at edge M: irq low after M.
- IRQMASK write: irq follows combinationally from the cycle after the write edge.
- Pulses on gpio_in shorter than one clk period may be missed.

## Configuration
- PIO_GPIO_EDGE_IRQ_EN defined: the edge detector, the edgecap and irqmask registers, and irq are implemented as above.
- PIO_GPIO_EDGE_IRQ_EN undefined:
  - No prev, edgecap or irqmask flops are built.
  - Addresses 2 and 3 read 0 and ignore writes.
  - irq is tied to 0.
  - EDGE_TYPE is unused. Input synchronisation and DATA reads are unchanged.

## Test plan
- Reset, WIDTH=8, RESET_OUT=8'hA5, RESET_DIR=8'hF0 -> gpio_out=A5, gpio_oe=F0, irq=0; read 0 = {F0&A5 | input bits}; read 2 = 0; read 3 = 0.
- Write DIR=FF, DATA=0x0F, OUTSET=0x30, OUTCLR=0x03 -> gpio_out is 0F, then 3F, then 3C, each one cycle after its write; read 0 = 0x3C.
- DIR=00, EDGE_TYPE=0, IRQMASK=0x01, gpio_in[0] rises before edge N -> read 0 bit0 = 1 after N+1; edgecap=0x01 and irq=1 at N+2; write 3 with 0x01 -> irq=0 next cycle.
- Edge on bit2 arriving in the same cycle as a W1C of bit2 -> edgecap bit2 remains 1; an edge on bit2 with IRQMASK bit2 = 0 -> irq stays 0.
- EDGE_TYPE=2: gpio_in[1] pulses 0->1->0 over 4 cycles with a W1C between the edges -> the capture sets on both edges.
- Assert reset mid-capture with edgecap=0xFF -> all outputs return to reset values asynchronously. Build without PIO_GPIO_EDGE_IRQ_EN -> irq constant 0, reads of 2 and 3 return 0.
